// File: rtl/otp_access_sequencer_pkg.sv
// Shared types and defaults for the OTP access sequencer.
// Holds the FSM state encoding, address widths, macro timing defaults and bit-select helper.
package otp_seq_pkg;
   localparam int OTP_ABITS  = 10;
   localparam int BYTE_ABITS = 7;

   localparam int T_SETUP_DEF = 2;
   localparam int T_RD_DEF    = 4;
   localparam int T_PGM_DEF   = 50;
   localparam int T_HOLD_DEF  = 2;
   localparam int T_VQ_DEF    = 10;
   localparam int N_BOOT_DEF  = 16;

   localparam int T_MAX = (T_PGM_DEF > T_VQ_DEF) ? T_PGM_DEF : T_VQ_DEF;
   localparam int CNT_W = $clog2(T_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, ARB, RD_SETUP, RD_STRB, RD_HOLD, RD_DONE,
      PG_VQON, PG_SETUP, PG_STRB, PG_HOLD, PG_GAP, PG_VQOFF, DONE
   } state_t;

   // Lowest set bit; bits are burned in ascending order.
   function automatic logic [2:0] first_one(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction
endpackage

// File: rtl/otp_access_sequencer_if.sv
// Host port, register-file xbus and OTP macro pins of the access sequencer.
// The sequencer takes the slave side; the surrounding controller or bench drives the master side.
interface otp_access_sequencer_if;
   import otp_seq_pkg::*;

   logic                  boot_en;
   logic                  i_run_test_mode;
   logic                  host_req;
   logic                  host_wr;
   logic [BYTE_ABITS-1:0] host_addr;
   logic [7:0]            host_wdata;
   logic                  host_ack;
   logic                  host_err;
   logic [7:0]            host_rdata;
   logic                  busy;
   logic                  boot_done;
   logic [BYTE_ABITS-1:0] xbus_addr;
   logic [7:0]            xbus_din;
   logic                  xbus_wr;
   logic                  o_otp_vddqsw;
   logic                  o_otp_csb;
   logic                  o_otp_strobe;
   logic                  o_otp_load;
   logic                  o_otp_pgenb;
   logic [OTP_ABITS-1:0]  o_otp_addr;
   logic [7:0]            i_otp_q;

   modport slave (
      input  boot_en, i_run_test_mode, host_req, host_wr, host_addr, host_wdata, i_otp_q,
      output host_ack, host_err, host_rdata, busy, boot_done, xbus_addr, xbus_din, xbus_wr,
             o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_addr
   );

   modport master (
      output boot_en, i_run_test_mode, host_req, host_wr, host_addr, host_wdata, i_otp_q,
      input  host_ack, host_err, host_rdata, busy, boot_done, xbus_addr, xbus_din, xbus_wr,
             o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_addr
   );
endinterface

// File: rtl/otp_access_sequencer_phase_timer.sv
// Loadable down-counter timing every sequencer phase; done is high while the count is zero.
// A phase loaded with D-1 therefore lasts exactly D cycles.
module otp_phase_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         done
);
   always_ff @(posedge clk) begin
      if (rst)                value <= '0;
      else if (load)          value <= load_val;
      else if (value != '0)   value <= value - W'(1);
   end

   assign done = (value == '0);
endmodule

// File: rtl/otp_access_sequencer.sv
// Sequences boot-copy reads and host read/program accesses onto the OTP macro pins with fixed timing.
// Host read acks T_SETUP+T_RD+T_HOLD+1 cycles after accept; host_req waits in IDLE while boot runs.
module otp_access_sequencer
   import otp_seq_pkg::*;
#(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_RD    = T_RD_DEF,
   parameter int T_PGM   = T_PGM_DEF,
   parameter int T_HOLD  = T_HOLD_DEF,
   parameter int T_VQ    = T_VQ_DEF,
   parameter int N_BOOT  = N_BOOT_DEF,
   parameter logic [BYTE_ABITS-1:0] XBUS_BASE = 7'd0
) (
   input logic                    sys_clk,
   input logic                    rst,
   otp_access_sequencer_if.slave  bus
);
   state_t state, nxt;
   logic src_boot, src_nxt, wr_q, wr_nxt, tm_q, tm_nxt, bdone_q, bdone_nxt;
   logic ack_nxt, err_nxt, xwr_nxt;
   logic [BYTE_ABITS-1:0] byte_q, byte_nxt, xaddr_q, xaddr_nxt;
   logic [7:0] bits_q, bits_nxt, data_q, data_nxt, xdin_q, xdin_nxt, rdata_q, rdata_nxt;
   logic [OTP_ABITS-1:0] addr_q, addr_nxt;
   logic [2:0] fb;
   logic tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val, tmr_value;

   otp_phase_timer #(.W(CNT_W)) u_timer (
      .clk(sys_clk), .rst(rst), .load(tmr_load), .load_val(tmr_val),
      .value(tmr_value), .done(tmr_done)
   );

   assign fb = first_one(bits_q);

   always_comb begin
      nxt = state;        src_nxt = src_boot;  wr_nxt = wr_q;       tm_nxt = tm_q;
      byte_nxt = byte_q;  bits_nxt = bits_q;   data_nxt = data_q;   addr_nxt = addr_q;
      xaddr_nxt = xaddr_q; xdin_nxt = xdin_q;  rdata_nxt = rdata_q; bdone_nxt = bdone_q;
      ack_nxt = 1'b0;     err_nxt = 1'b0;      xwr_nxt = 1'b0;
      tmr_load = 1'b0;    tmr_val = '0;
      case (state)
         IDLE: begin
            if (bus.boot_en && !bdone_q) begin
               nxt = ARB; src_nxt = 1'b1; byte_nxt = '0;
            end else if (bus.host_req) begin
               nxt = ARB; src_nxt = 1'b0; wr_nxt = bus.host_wr; tm_nxt = bus.i_run_test_mode;
               byte_nxt = bus.host_addr; bits_nxt = bus.host_wdata;
            end
         end
         ARB: begin
            if (src_boot || !wr_q) begin
               nxt = RD_SETUP; tmr_load = 1'b1; tmr_val = CNT_W'(T_SETUP - 1);
               addr_nxt = {byte_q, 3'b000};
            end else if (!tm_q || bits_q == 8'h00) begin
               nxt = DONE; ack_nxt = 1'b1; err_nxt = !tm_q;
            end else begin
               nxt = PG_VQON; tmr_load = 1'b1; tmr_val = CNT_W'(T_VQ - 1);
            end
         end
         RD_SETUP: if (tmr_done) begin
            nxt = RD_STRB; tmr_load = 1'b1; tmr_val = CNT_W'(T_RD - 1);
         end
         RD_STRB: begin
            if (tmr_value == '0) data_nxt = bus.i_otp_q;
            if (tmr_done) begin
               nxt = RD_HOLD; tmr_load = 1'b1; tmr_val = CNT_W'(T_HOLD - 1);
            end
         end
         RD_HOLD: if (tmr_done) begin
            nxt = RD_DONE;
            if (src_boot) begin
               xwr_nxt = 1'b1; xaddr_nxt = XBUS_BASE + byte_q; xdin_nxt = data_q;
            end else begin
               ack_nxt = 1'b1; rdata_nxt = data_q;
            end
         end
         RD_DONE: begin
            if (src_boot && byte_q != BYTE_ABITS'(N_BOOT - 1)) begin
               nxt = RD_SETUP; tmr_load = 1'b1; tmr_val = CNT_W'(T_SETUP - 1);
               byte_nxt = byte_q + 7'd1; addr_nxt = {byte_q + 7'd1, 3'b000};
            end else begin
               nxt = DONE; bdone_nxt = bdone_q | src_boot;
            end
         end
         PG_VQON: if (tmr_done) begin
            nxt = PG_SETUP; tmr_load = 1'b1; tmr_val = CNT_W'(T_SETUP - 1);
            addr_nxt = {byte_q, fb};
         end
         PG_SETUP: if (tmr_done) begin
            nxt = PG_STRB; tmr_load = 1'b1; tmr_val = CNT_W'(T_PGM - 1);
         end
         PG_STRB: if (tmr_done) begin
            nxt = PG_HOLD; tmr_load = 1'b1; tmr_val = CNT_W'(T_HOLD - 1);
         end
         PG_HOLD: if (tmr_done) begin
            nxt = PG_GAP; bits_nxt = bits_q & ~(8'd1 << fb);
         end
         PG_GAP: begin
            tmr_load = 1'b1;
            if (bits_q != 8'h00) begin
               nxt = PG_SETUP; tmr_val = CNT_W'(T_SETUP - 1); addr_nxt = {byte_q, fb};
            end else begin
               nxt = PG_VQOFF; tmr_val = CNT_W'(T_VQ - 1);
            end
         end
         PG_VQOFF: if (tmr_done) begin
            nxt = DONE; ack_nxt = 1'b1;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Pins are decoded from the next state so each one is a flop aligned with the state register.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= IDLE;   src_boot <= 1'b0; wr_q <= 1'b0;   tm_q <= 1'b0;   bdone_q <= 1'b0;
         byte_q <= '0;    bits_q <= '0;     data_q <= '0;   addr_q <= '0;
         xaddr_q <= '0;   xdin_q <= '0;     rdata_q <= '0;
         bus.host_ack <= 1'b0;     bus.host_err <= 1'b0;    bus.xbus_wr <= 1'b0;
         bus.busy <= 1'b0;         bus.o_otp_csb <= 1'b1;   bus.o_otp_strobe <= 1'b0;
         bus.o_otp_load <= 1'b0;   bus.o_otp_pgenb <= 1'b1; bus.o_otp_vddqsw <= 1'b0;
      end else begin
         state <= nxt;       src_boot <= src_nxt;  wr_q <= wr_nxt;     tm_q <= tm_nxt;
         bdone_q <= bdone_nxt; byte_q <= byte_nxt; bits_q <= bits_nxt; data_q <= data_nxt;
         addr_q <= addr_nxt; xaddr_q <= xaddr_nxt; xdin_q <= xdin_nxt; rdata_q <= rdata_nxt;
         bus.host_ack     <= ack_nxt;
         bus.host_err     <= err_nxt;
         bus.xbus_wr      <= xwr_nxt;
         bus.busy         <= (nxt != IDLE);
         bus.o_otp_csb    <= !(nxt inside {RD_SETUP, RD_STRB, RD_HOLD, PG_SETUP, PG_STRB, PG_HOLD});
         bus.o_otp_strobe <= (nxt inside {RD_STRB, PG_STRB});
         bus.o_otp_load   <= (nxt inside {RD_SETUP, RD_STRB, RD_HOLD});
         bus.o_otp_pgenb  <= !(nxt inside {PG_SETUP, PG_STRB, PG_HOLD});
         bus.o_otp_vddqsw <= (nxt inside {PG_VQON, PG_SETUP, PG_STRB, PG_HOLD, PG_GAP, PG_VQOFF});
      end
   end

   assign bus.o_otp_addr = addr_q;
   assign bus.xbus_addr  = xaddr_q;
   assign bus.xbus_din   = xdin_q;
   assign bus.host_rdata = rdata_q;
   assign bus.boot_done  = bdone_q;
endmodule
